// File: rtl/sequencia_fade.sv
// Fading LED trail driven by a one-hot ping-pong position, with protocol check.
// Define SEQUENCIA_FADE_VOLTAS_EN to build the round-trip counter on voltas.
module sequencia_fade #(
    parameter int PWM_BITS = 4,
    parameter int DECAY    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       passo,
    input  logic [3:0] sequencia,
    output logic [3:0] led,
    output logic       erro,
    output logic [7:0] voltas
);

    localparam logic [PWM_BITS-1:0] FULL = '1;
    localparam logic [PWM_BITS-1:0] DEC  = PWM_BITS'(DECAY);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] brilho_q [4];
    logic [PWM_BITS-1:0] brilho_d [4];
    logic [3:0]          led_q, led_d;
    logic [3:0]          ant_q, ant_d;
    logic                ant_ok_q, ant_ok_d;
    logic                erro_q, erro_d;
    logic                one_hot, adjacent, legal;

    always_comb begin
        one_hot  = (sequencia != 4'd0) &&
                   ((sequencia & (sequencia - 4'd1)) == 4'd0);
        // Before the first legal step there is nothing to compare against.
        adjacent = !ant_ok_q ||
                   (sequencia == {ant_q[2:0], 1'b0}) ||
                   (sequencia == {1'b0, ant_q[3:1]});
        legal    = one_hot && adjacent;
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        ant_d     = ant_q;
        ant_ok_d  = ant_ok_q;
        erro_d    = erro_q;
        for (int i = 0; i < 4; i++) begin
            brilho_d[i] = brilho_q[i];
            led_d[i]    = (pwm_cnt_q < brilho_q[i]);
        end
        if (passo) begin
            for (int i = 0; i < 4; i++) begin
                if (sequencia[i])
                    brilho_d[i] = FULL;
                else if (brilho_q[i] > DEC)
                    brilho_d[i] = brilho_q[i] - DEC;
                else
                    brilho_d[i] = '0;
            end
            if (legal) begin
                ant_d    = sequencia;
                ant_ok_d = 1'b1;
            end else begin
                erro_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
            ant_q     <= '0;
            ant_ok_q  <= 1'b0;
            erro_q    <= 1'b0;
            for (int i = 0; i < 4; i++)
                brilho_q[i] <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            ant_q     <= ant_d;
            ant_ok_q  <= ant_ok_d;
            erro_q    <= erro_d;
            for (int i = 0; i < 4; i++)
                brilho_q[i] <= brilho_d[i];
        end
    end

    assign led  = led_q;
    assign erro = erro_q;

`ifdef SEQUENCIA_FADE_VOLTAS_EN
    logic [7:0] voltas_q, voltas_d;
    logic       volta;

    // A round trip completes when the trail returns from LED1 to LED0.
    always_comb begin
        volta    = passo && legal &&
                   (ant_q == 4'b0010) && (sequencia == 4'b0001);
        voltas_d = volta ? voltas_q + 8'd1 : voltas_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            voltas_q <= 8'd0;
        else
            voltas_q <= voltas_d;
    end

    assign voltas = voltas_q;
`else
    assign voltas = 8'd0;
`endif

endmodule

// File: tb/tb_sequencia_fade.sv
// Randomized self-checking bench for sequencia_fade against a step-level model.
// Honours SEQUENCIA_FADE_VOLTAS_EN the same way the design does.
module tb_sequencia_fade;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       passo = 1'b0;
    logic [3:0] sequencia = 4'd0;
    logic [3:0] led;
    logic       erro;
    logic [7:0] voltas;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SEQUENCIA_FADE_VOLTAS_EN
    localparam bit VOLTAS_EN = 1'b1;
`else
    localparam bit VOLTAS_EN = 1'b0;
`endif

    sequencia_fade #(.PWM_BITS(4), .DECAY(4)) dut (
        .clk(clk),
        .rst(rst),
        .passo(passo),
        .sequencia(sequencia),
        .led(led),
        .erro(erro),
        .voltas(voltas)
    );

    always #5 clk = ~clk;

    // Step-level model: brightness per LED, last legal position, flags.
    int m_br [4];
    int m_ant;
    bit m_ok;
    bit m_err;
    int m_volt;
    int duty [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_br[i] = 0;
        m_ant  = 0;
        m_ok   = 0;
        m_err  = 0;
        m_volt = 0;
    endtask

    task automatic model_step(input logic [3:0] s);
        int  v;
        bit  lg;
        v  = int'(s);
        lg = ($countones(s) == 1) &&
             (!m_ok || v == 2 * m_ant || 2 * v == m_ant);
        for (int i = 0; i < 4; i++)
            m_br[i] = s[i] ? 15 : ((m_br[i] > 4) ? m_br[i] - 4 : 0);
        if (lg) begin
            if (VOLTAS_EN && m_ant == 2 && v == 1)
                m_volt = (m_volt + 1) % 256;
            m_ant = v;
            m_ok  = 1;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Drives one strobe starting at a negedge; returns at the next negedge.
    task automatic do_step(input logic [3:0] s);
        passo     = 1'b1;
        sequencia = s;
        @(negedge clk);
        passo = 1'b0;
        model_step(s);
    endtask

    // 16 consecutive cycles cover every PWM count exactly once.
    task automatic measure();
        for (int i = 0; i < 4; i++) duty[i] = 0;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (led[i]) duty[i]++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({led, erro, voltas} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: led=%b erro=%b voltas=%0d want 0",
                     led, erro, voltas);
        end
    endtask

    task automatic test_single();
        do_reset();
        do_step(4'b0001);
        measure();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (duty[i] != ((i == 0) ? 15 : 0)) begin
                n_fail++;
                $display("FAIL single_duty[%0d]: got %0d want %0d",
                         i, duty[i], (i == 0) ? 15 : 0);
            end
        end
    endtask

    task automatic test_decay();
        int want [4];
        do_reset();
        do_step(4'b0001);
        do_step(4'b0010);
        do_step(4'b0100);
        do_step(4'b1000);
        measure();
        want = '{3, 7, 11, 15};
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (duty[i] != want[i] || m_br[i] != want[i]) begin
                n_fail++;
                $display("FAIL decay_duty[%0d]: got %0d want %0d",
                         i, duty[i], want[i]);
            end
        end
        do_step(4'b0100);
        do_step(4'b0010);
        measure();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (duty[i] != m_br[i]) begin
                n_fail++;
                $display("FAIL decay_sat[%0d]: got %0d want %0d",
                         i, duty[i], m_br[i]);
            end
        end
        n_chk++;
        if (duty[0] != 0 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL led0_saturate: duty=%0d erro=%b want 0 0",
                     duty[0], erro);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] pat [6];
        pat = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_reset();
        do_step(4'b0001);
        repeat (3)
            for (int i = 0; i < 6; i++) begin
                do_step(pat[i]);
                n_chk++;
                if (voltas !== 8'(m_volt) || erro !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep: voltas=%0d erro=%b want %0d 0",
                             voltas, erro, m_volt);
                end
            end
        n_chk++;
        if (voltas !== (VOLTAS_EN ? 8'd3 : 8'd0)) begin
            n_fail++;
            $display("FAIL sweep_total: voltas=%0d want %0d",
                     voltas, VOLTAS_EN ? 3 : 0);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        do_step(4'b0001);
        do_step(4'b0110);
        n_chk++;
        if (erro !== 1'b1) begin
            n_fail++;
            $display("FAIL two_hot_erro: got %b want 1", erro);
        end
        measure();
        n_chk++;
        if (duty[1] != 15 || duty[2] != 15 || duty[0] != 11) begin
            n_fail++;
            $display("FAIL two_hot_duty: got %0d %0d %0d want 11 15 15",
                     duty[0], duty[1], duty[2]);
        end
        // ant is still 0001, so 0010 then 0001 is a legal round trip.
        do_step(4'b0010);
        do_step(4'b0001);
        n_chk++;
        if (erro !== 1'b1 || voltas !== 8'(m_volt)) begin
            n_fail++;
            $display("FAIL two_hot_after: erro=%b voltas=%0d want 1 %0d",
                     erro, voltas, m_volt);
        end
    endtask

    task automatic test_jump();
        do_reset();
        do_step(4'b0001);
        do_step(4'b0100);
        n_chk++;
        if (erro !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_erro: got %b want 1", erro);
        end
        do_step(4'b0010);
        do_step(4'b0001);
        n_chk++;
        if (voltas !== (VOLTAS_EN ? 8'd1 : 8'd0) || erro !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_ant: voltas=%0d erro=%b want %0d 1",
                     voltas, erro, VOLTAS_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pat [6];
        pat = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_reset();
        do_step(4'b0001);
        repeat (5)
            for (int i = 0; i < 6; i++) do_step(pat[i]);
        do_step(4'b0010);
        do_step(4'b0010);
        n_chk++;
        if (voltas !== 8'(m_volt) || erro !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: voltas=%0d erro=%b want %0d 1",
                     voltas, erro, m_volt);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({led, erro, voltas} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: led=%b erro=%b voltas=%0d want 0",
                     led, erro, voltas);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        do_step(4'b1000);
        n_chk++;
        if (erro !== 1'b0) begin
            n_fail++;
            $display("FAIL first_after_reset: erro=%b want 0", erro);
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        bit         p;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            p = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0)
                s = 4'($urandom);
            else if (m_ant == 0)
                s = 4'(1 << $urandom_range(0, 3));
            else if (m_ant == 1)
                s = 4'b0010;
            else if (m_ant == 8)
                s = 4'b0100;
            else
                s = $urandom_range(0, 1) ? 4'(m_ant * 2) : 4'(m_ant / 2);
            passo     = p;
            sequencia = p ? s : 4'($urandom);
            @(negedge clk);
            if (p) model_step(s);
            n_chk++;
            if (erro !== m_err || voltas !== 8'(m_volt)) begin
                n_fail++;
                $display("FAIL random[%0d]: erro=%b voltas=%0d want %b %0d",
                         c, erro, voltas, m_err, m_volt);
            end
        end
        passo     = 1'b0;
        sequencia = 4'($urandom);
        measure();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (duty[i] != m_br[i]) begin
                n_fail++;
                $display("FAIL random_duty[%0d]: got %0d want %0d",
                         i, duty[i], m_br[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_decay();
        test_sweep();
        test_illegal();
        test_jump();
        test_reset_mid();
        test_random();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sequencia_fade.md
# sequencia_fade

Downstream consumer of the 4-bit one-hot ping-pong position generator. On each step strobe it samples the one-hot position and turns it into a fading "trail" on four PWM-driven LED outputs. It also checks that the incoming pattern is a legal one-hot, one-position move, and counts completed round trips. It sits between the position generator and the board LED pins.

## Interface
- `PWM_BITS`, default 4: width of the brightness registers and of the PWM counter. Full scale is 2^PWM_BITS-1.
- `DECAY`, default 4: amount subtracted from each non-active LED's brightness per step. Range 1..2^PWM_BITS-1.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Outputs go to reset values immediately when `rst`=0.
- `passo`, input, 1: step strobe, one `clk` wide. `sequencia` is sampled only when `passo`=1.
- `sequencia`, input, 4: position pattern from the generator; legally one-hot.
- `led`, output, 4: PWM LED drive, registered.
- `erro`, output, 1: sticky protocol-error flag, registered.
- `voltas`, output, 8: count of completed round trips, registered.

## Operation
- Free-running counter `pwm_cnt` (PWM_BITS wide): increments every `clk`, wraps from 2^PWM_BITS-1 to 0. Runs regardless of `passo`.
- Per-LED brightness register `brilho[i]` (PWM_BITS wide), i=0..3.
- On an edge with `passo`=1:
  - If `sequencia[i]`=1: `brilho[i]` <= 2^PWM_BITS-1.
  - Otherwise, saturating decay: `brilho[i]` <= (`brilho[i]` > DECAY) ? `brilho[i]`-DECAY : 0.
- If `passo`=0, `brilho` holds.
- `led[i]` <= (`pwm_cnt` < `brilho[i]`), unsigned compare. Brightness 0 gives duty 0; full scale gives duty (2^N-1)/2^N.
- Position tracking: register `ant` (4 bits) holds the last legal position and a flag `ant_ok`. Both reset to 0.
- Legality check on `passo`=1:
  - Illegal if `sequencia` does not have exactly one bit set.
  - Also illegal if `ant_ok`=1 and `sequencia` is neither `ant`<<1 nor `ant`>>1.
- On illegal input: `erro` <= 1. `erro` is sticky and clears only on reset. `ant`/`ant_ok` do not update. Brightness still updates per bit, so every set bit jumps to full scale.
- On legal input: `ant` <= `sequencia`, `ant_ok` <= 1.
- The first `passo` after reset checks only the one-hot rule.
- Round trip: on a legal step where `ant`=4'b0010 and `sequencia`=4'b0001, `voltas` <= `voltas`+1. Wraps 255 -> 0.

## Timing
- Reset values: `led`=0, `erro`=0, `voltas`=0, `brilho`=0, `pwm_cnt`=0, `ant`=0, `ant_ok`=0.
- `passo` sampled at edge k: `brilho`, `erro`, `voltas`, `ant` are updated at edge k. `led` reflects the new brightness from edge k+1 (one register stage).
- Back-to-back `passo` on consecutive cycles is legal. Each one is a full step.
- Reset asserted mid-sweep: all state clears asynchronously. The next `passo` is treated as the first.
- `sequencia` changes while `passo`=0 are ignored.

## Configuration
- `SEQUENCIA_FADE_VOLTAS_EN` defined: the round-trip counter is built and `voltas` behaves as above.
- `SEQUENCIA_FADE_VOLTAS_EN` undefined: the counter is not built and `voltas` is tied to 8'd0. Other behaviour is unchanged.

## Test plan
All scenarios use the defaults PWM_BITS=4, DECAY=4.
- Reset, then a single `passo` with `sequencia`=0001:
  - `brilho[0]`=15, the others 0.
  - Over the next 16 cycles `led[0]` is high for 15 and low for 1; `led[3:1]` stay 0.
- Steps 0001, 0010, 0100, 1000:
  - After the fourth step, `brilho` = {15, 11, 7, 3} for LEDs 3..0.
  - Two more steps 0100, 0010 give LED0=0 (saturates, does not wrap).
- Full legal sweep 0001→0010→0100→1000→0100→0010→0001, repeated 3 times:
  - `voltas`=3, `erro`=0.
  - With the macro undefined, `voltas`=0 throughout.
- `passo` with `sequencia`=0110:
  - `erro`=1 at the next edge; LEDs 1 and 2 go to 15.
  - A following legal step leaves `erro`=1 and compares against the prior legal `ant`.
- Legal 0001 then 0100 (jump of two):
  - `erro`=1, `ant` stays 0001.
  - A following 0010 step is accepted as legal.
- Reset pulsed low mid-sweep with `voltas`=5 and `erro`=1:
  - All outputs are 0 immediately.
  - First `passo` with 1000 is accepted with no adjacency error.
